clkgen_multi_ch: RTL and testbench
==================================

Name: clkgen_multi_ch

Overview:
- Parametrised, fully digital successor to the system clock-generation block.
- Derives NUM_CH programmable clock outputs from one reference clock. Each output has its own runtime-configurable integer divide ratio, high time (duty) and phase offset.
- Provides a single-cycle edge-enable per channel and a lock indicator that deasserts during reconfiguration.
- Sits between the board reference clock and peripheral cores (SDRAM, motor PWM, LCD timing). Outputs are intended as clock enables or low-speed clocks.

Parameters:
- NUM_CH, 2, number of output channels (1..8).
- CNT_W, 16, width of divide/high/phase counters.
- LOCK_CYCLES, 16, refclk cycles from channel restart to locked assertion (>=1).
- DIV_INIT, 2, reset divide ratio for every channel (>=2).
- HIGH_INIT, 1, reset high time for every channel (1..DIV_INIT-1).

Ports:
- refclk  in  1  reference clock; all logic is in this domain.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised internally with a 2-flop synchroniser.
- run  in  1  1 = channels toggle; 0 = all channels stopped, outputs low.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration accepted when cfg_valid and cfg_ready are both high.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- cfg_div  in  CNT_W  divide ratio N; output period = N refclk cycles.
- cfg_high  in  CNT_W  high cycles per period.
- cfg_phase  in  CNT_W  rising-edge delay, in refclk cycles, after a common restart.
- cfg_err  out  1  one-cycle pulse when a request is rejected.
- outclk  out  NUM_CH  registered divided clocks.
- outclk_en  out  NUM_CH  one-cycle pulse in the cycle each outclk rises.
- locked  out  1  all channels running with current configuration and settled.

Behaviour:
- Reset (async, rst_n=0):
  - outclk=0, outclk_en=0, locked=0, cfg_ready=0, cfg_err=0, FSM=STOP.
  - Every channel: div=DIV_INIT, high=HIGH_INIT, phase=0.
- Per-channel counter cnt runs 0..div-1 and wraps to 0.
  - outclk is registered 1 while cnt < high, else 0.
  - outclk_en=1 in the cycle cnt==0, aligned with outclk rising.
- Restart: on restart, each channel loads cnt = (div - phase) mod div, with outclk=0 and outclk_en=0. Its first outclk_en pulse therefore occurs exactly phase cycles after the first RUN cycle; phase=0 means the pulse is in the first RUN cycle.
- FSM:
  - STOP:
    - outputs low; locked=0; cfg_ready=1.
    - run=1 -> RESTART.
  - RESTART (1 cycle):
    - load all counters as above; clear settle counter.
    - -> SETTLE.
  - SETTLE:
    - channels count; settle counter increments each cycle.
    - when it reaches LOCK_CYCLES-1 -> LOCKED.
    - cfg_ready=0.
  - LOCKED:
    - locked=1; cfg_ready=1.
    - accepted valid config -> RECONFIG.
    - run=0 -> STOP.
  - RECONFIG (1 cycle):
    - write the target channel registers; locked=0; all outputs low.
    - -> RESTART. All channels restart together, so relative phases are preserved.
- run=0 in any state -> STOP on the next cycle; outputs low that cycle; locked=0.
- Config in STOP: registers are written directly and the FSM stays in STOP. The new values apply at the next RESTART.
- Validation, evaluated combinationally at handshake: reject if any of
  - cfg_div<2,
  - cfg_high==0,
  - cfg_high>=cfg_div,
  - cfg_phase>=cfg_div,
  - cfg_ch>=NUM_CH.
  On reject: cfg_err pulses the cycle after the handshake, registers are unchanged, the FSM does not leave its state, and locked stays unchanged.
- Simultaneous cfg handshake and run 1->0 in LOCKED: run wins, FSM -> STOP, and the config is still written if valid.
- Width rules:
  - all comparisons are unsigned CNT_W;
  - the settle counter is $clog2(LOCK_CYCLES+1) bits and saturates;
  - no counter exceeds div-1.
- rst_n asserted mid-operation: immediate async clear to reset values; the configuration is lost.

Test Plan:
- Reset defaults: release rst_n, run=1, defaults DIV_INIT=2, HIGH_INIT=1 -> each outclk toggles every cycle; locked rises 1+LOCK_CYCLES cycles after the first run cycle.
- Divide and phase: in LOCKED, write ch1 div=5, high=2, phase=3 -> locked low for 1+1+LOCK_CYCLES cycles.
  - ch1 pattern 11000 repeating; its first outclk_en occurs 3 cycles after ch0's first outclk_en post-restart.
  - cfg_err stays 0.
- Illegal config: write ch0 div=4, high=4 -> cfg_err single pulse; locked stays 1; ch0 waveform unchanged. Repeat with div=1, phase=4/div=4, and cfg_ch=NUM_CH.
- Stop/run: run=0 in LOCKED -> next cycle all outclk=0, locked=0.
  - Write ch0 div=3, high=1 while stopped -> FSM stays in STOP.
  - run=1 -> ch0 period 3 with duty 1/3; locked after LOCK_CYCLES.
- Simultaneous events: cfg handshake with run falling in the same cycle -> FSM in STOP; the new config is visible after run=1.
- Async reset mid-SETTLE: drop rst_n for 1 ns off-edge -> outputs 0 immediately; all channel registers back to DIV_INIT/HIGH_INIT/0.

Source files
------------

// File: rtl/clkgen_multi_ch.sv
// Multi-channel programmable clock / clock-enable generator.
// Every channel divides refclk with its own ratio, high time and phase.
module clkgen_multi_ch #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int LOCK_CYCLES = 16,
    parameter int DIV_INIT    = 2,
    parameter int HIGH_INIT   = 1
) (
    input  logic                                  refclk,
    input  logic                                  rst_n,
    input  logic                                  run,
    input  logic                                  cfg_valid,
    output logic                                  cfg_ready,
    input  logic [((NUM_CH>1)?$clog2(NUM_CH):1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                      cfg_div,
    input  logic [CNT_W-1:0]                      cfg_high,
    input  logic [CNT_W-1:0]                      cfg_phase,
    output logic                                  cfg_err,
    output logic [NUM_CH-1:0]                     outclk,
    output logic [NUM_CH-1:0]                     outclk_en,
    output logic                                  locked
);

    localparam int SET_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_STOP,
        ST_RESTART,
        ST_SETTLE,
        ST_LOCKED,
        ST_RECONFIG
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [1:0]       r_sync;
    logic             w_rst_n;
    logic [SET_W-1:0] r_settle;
    logic             r_err;

    logic [CNT_W-1:0] r_div   [NUM_CH];
    logic [CNT_W-1:0] r_high  [NUM_CH];
    logic [CNT_W-1:0] r_phase [NUM_CH];
    logic [CNT_W-1:0] r_cnt   [NUM_CH];
    logic [CNT_W-1:0] w_load  [NUM_CH];
    logic [CNT_W-1:0] w_cur   [NUM_CH];
    logic [NUM_CH-1:0] w_wrap;
    logic [NUM_CH-1:0] r_out;
    logic [NUM_CH-1:0] r_en;

    logic [31:0] w_ch_ext;
    logic        w_hs;
    logic        w_cfg_ok;
    logic        w_wr;
    logic        w_count;

    // Reset asserts asynchronously, releases two refclk edges later.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_sync[1];

    assign cfg_ready = w_rst_n &
                       ((r_state == ST_STOP) | (r_state == ST_LOCKED));

    assign w_ch_ext = 32'(cfg_ch);
    assign w_hs     = cfg_valid & cfg_ready;
    assign w_cfg_ok = (cfg_div >= CNT_W'(2)) &&
                      (cfg_high != '0) &&
                      (cfg_high < cfg_div) &&
                      (cfg_phase < cfg_div) &&
                      (w_ch_ext < 32'(NUM_CH));
    assign w_wr     = w_hs & w_cfg_ok;

    always_comb begin
        w_next = r_state;
        if (!run) begin
            w_next = ST_STOP;
        end else begin
            case (r_state)
                ST_STOP:     w_next = ST_RESTART;
                ST_RESTART:  w_next = ST_SETTLE;
                ST_SETTLE: begin
                    if (r_settle == SET_W'(LOCK_CYCLES - 1)) begin
                        w_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    if (w_wr) begin
                        w_next = ST_RECONFIG;
                    end
                end
                ST_RECONFIG: w_next = ST_RESTART;
                default:     w_next = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge refclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state  <= ST_STOP;
            r_settle <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_hs & ~w_cfg_ok;
            if (r_state == ST_RESTART) begin
                r_settle <= '0;
            end else if ((r_state == ST_SETTLE) && (r_settle != '1)) begin
                r_settle <= r_settle + SET_W'(1);
            end
        end
    end

    // Outputs are registered for the cycle that follows, so the decision
    // keys off the next state; RESTART feeds the phase-adjusted start count.
    assign w_count = (w_next == ST_SETTLE) | (w_next == ST_LOCKED);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_load[i] = (r_phase[i] == '0) ? '0 : (r_div[i] - r_phase[i]);
            w_cur[i]  = (r_state == ST_RESTART) ? w_load[i] : r_cnt[i];
            w_wrap[i] = (w_cur[i] >= (r_div[i] - CNT_W'(1)));
        end
    end

    always_ff @(posedge refclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]   <= CNT_W'(DIV_INIT);
                r_high[i]  <= CNT_W'(HIGH_INIT);
                r_phase[i] <= '0;
                r_cnt[i]   <= '0;
            end
            r_out <= '0;
            r_en  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_wr && (w_ch_ext == 32'(i))) begin
                    r_div[i]   <= cfg_div;
                    r_high[i]  <= cfg_high;
                    r_phase[i] <= cfg_phase;
                end
                if (w_count) begin
                    r_cnt[i] <= w_wrap[i] ? '0 : (w_cur[i] + CNT_W'(1));
                    r_out[i] <= (w_cur[i] < r_high[i]);
                    r_en[i]  <= (w_cur[i] == '0);
                end else begin
                    r_cnt[i] <= '0;
                    r_out[i] <= 1'b0;
                    r_en[i]  <= 1'b0;
                end
            end
        end
    end

    assign outclk    = r_out;
    assign outclk_en = r_en;
    assign cfg_err   = r_err;
    assign locked    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_clkgen_multi_ch.sv
// Directed bench for clkgen_multi_ch with three channels.
// Config request table plus hand-written stop/run/reset sequences.
module tb_clkgen_multi_ch;

    localparam int NCH = 3;
    localparam int LC  = 16;

    logic        refclk;
    logic        rst_n;
    logic        run;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [15:0] cfg_high;
    logic [15:0] cfg_phase;
    logic        cfg_err;
    logic [2:0]  outclk;
    logic [2:0]  outclk_en;
    logic        locked;

    clkgen_multi_ch #(
        .NUM_CH      (NCH),
        .CNT_W       (16),
        .LOCK_CYCLES (LC),
        .DIV_INIT    (2),
        .HIGH_INIT   (1)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .run       (run),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_high  (cfg_high),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .outclk    (outclk),
        .outclk_en (outclk_en),
        .locked    (locked)
    );

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] div;
        logic [15:0] high;
        logic [15:0] phase;
        logic        exp_err;
    } vec_t;

    vec_t tbl [7];

    int checks = 0;
    int errors = 0;
    int m_div   [NCH];
    int m_high  [NCH];
    int m_phase [NCH];

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge refclk);
    endtask

    task automatic set_defaults();
        for (int i = 0; i < NCH; i++) begin
            m_div[i]   = 2;
            m_high[i]  = 1;
            m_phase[i] = 0;
        end
    endtask

    // Expected {outclk_en, outclk} k cycles after the first counting cycle.
    function automatic logic [5:0] model(input int k);
        logic [2:0] o;
        logic [2:0] e;
        int ld;
        int c;
        for (int i = 0; i < NCH; i++) begin
            ld   = (m_phase[i] == 0) ? 0 : m_div[i] - m_phase[i];
            c    = (k + ld) % m_div[i];
            o[i] = (c < m_high[i]);
            e[i] = (c == 0);
        end
        return {e, o};
    endfunction

    // Entered pre cycles before the RESTART cycle; follows through lock.
    task automatic relock(input string nm, input int pre);
        int n;
        logic [5:0] e;
        n = 0;
        while (!locked && n < 200) begin
            e = (n > pre) ? model(n - pre - 1) : 6'd0;
            chk($sformatf("%s_wave%0d", nm, n),
                {25'd0, outclk_en, outclk, cfg_err}, {25'd0, e, 1'b0});
            cyc();
            n++;
        end
        chk({nm, "_lock_lat"}, n, pre + 1 + LC);
        for (int j = 0; j < 12; j++) begin
            e = model(n - pre - 1);
            chk($sformatf("%s_run%0d", nm, j),
                {24'd0, outclk_en, outclk, cfg_err, locked},
                {24'd0, e, 1'b0, 1'b1});
            cyc();
            n++;
        end
    endtask

    initial begin
        logic o0;

        tbl[0] = {2'd1, 16'd5, 16'd2, 16'd3, 1'b0};
        tbl[1] = {2'd0, 16'd4, 16'd4, 16'd0, 1'b1};
        tbl[2] = {2'd0, 16'd1, 16'd1, 16'd0, 1'b1};
        tbl[3] = {2'd0, 16'd4, 16'd1, 16'd4, 1'b1};
        tbl[4] = {2'd3, 16'd4, 16'd1, 16'd0, 1'b1};
        tbl[5] = {2'd0, 16'd4, 16'd0, 16'd0, 1'b1};
        tbl[6] = {2'd2, 16'd4, 16'd3, 16'd1, 1'b0};

        set_defaults();
        rst_n     = 1'b0;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_high  = '0;
        cfg_phase = '0;

        cyc(); cyc(); cyc();
        chk("rst_outclk", {29'd0, outclk}, 0);
        chk("rst_en", {29'd0, outclk_en}, 0);
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_ready", {31'd0, cfg_ready}, 0);
        chk("rst_err", {31'd0, cfg_err}, 0);

        rst_n = 1'b1;
        cyc();
        chk("sync_ready0", {31'd0, cfg_ready}, 0);
        cyc();
        chk("sync_ready1", {31'd0, cfg_ready}, 1);
        chk("stop_locked", {31'd0, locked}, 0);
        run = 1'b1;
        cyc();
        chk("restart_ready", {31'd0, cfg_ready}, 0);
        relock("boot", 0);

        for (int r = 0; r < 7; r++) begin
            o0        = outclk[0];
            cfg_ch    = tbl[r].ch;
            cfg_div   = tbl[r].div;
            cfg_high  = tbl[r].high;
            cfg_phase = tbl[r].phase;
            cfg_valid = 1'b1;
            chk($sformatf("row%0d_ready", r), {31'd0, cfg_ready}, 1);
            cyc();
            cfg_valid = 1'b0;
            chk($sformatf("row%0d_err", r), {31'd0, cfg_err},
                {31'd0, tbl[r].exp_err});
            chk($sformatf("row%0d_locked", r), {31'd0, locked},
                {31'd0, tbl[r].exp_err});
            if (tbl[r].exp_err) begin
                chk($sformatf("row%0d_ch0", r), {31'd0, outclk[0]},
                    {31'd0, ~o0});
                cyc();
                chk($sformatf("row%0d_err_pulse", r), {31'd0, cfg_err}, 0);
            end else begin
                m_div[tbl[r].ch]   = int'(tbl[r].div);
                m_high[tbl[r].ch]  = int'(tbl[r].high);
                m_phase[tbl[r].ch] = int'(tbl[r].phase);
                relock($sformatf("row%0d", r), 1);
            end
        end

        run = 1'b0;
        cyc();
        chk("stop_out", {28'd0, outclk, locked}, 0);
        chk("stop_en", {29'd0, outclk_en}, 0);
        cfg_ch    = 2'd0;
        cfg_div   = 16'd3;
        cfg_high  = 16'd1;
        cfg_phase = 16'd0;
        cfg_valid = 1'b1;
        chk("stop_cfg_ready", {31'd0, cfg_ready}, 1);
        cyc();
        cfg_valid = 1'b0;
        m_div[0]  = 3;
        m_high[0] = 1;
        chk("stop_cfg_err", {31'd0, cfg_err}, 0);
        chk("stop_stays", {28'd0, outclk, cfg_ready}, 1);
        cyc();
        chk("stop_hold", {28'd0, outclk, locked}, 0);
        run = 1'b1;
        cyc();
        relock("rerun", 0);

        run       = 1'b0;
        cfg_ch    = 2'd1;
        cfg_div   = 16'd4;
        cfg_high  = 16'd2;
        cfg_phase = 16'd0;
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        chk("simul_stop", {27'd0, outclk, locked, cfg_err}, 0);
        chk("simul_ready", {31'd0, cfg_ready}, 1);
        cyc();
        chk("simul_hold", {29'd0, outclk}, 0);
        m_div[1]   = 4;
        m_high[1]  = 2;
        m_phase[1] = 0;
        run = 1'b1;
        cyc();
        relock("simul", 0);

        run = 1'b0;
        cyc();
        run = 1'b1;
        cyc();
        cyc();
        chk("pre_rst_ch0", {31'd0, outclk[0]}, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {25'd0, outclk, outclk_en, locked}, 0);
        rst_n = 1'b1;
        cyc();
        chk("post_rst_ready0", {28'd0, outclk, cfg_ready}, 0);
        cyc();
        chk("post_rst_ready1", {31'd0, cfg_ready}, 1);
        set_defaults();
        cyc();
        relock("post_rst", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
